// File: rtl/scr1_memif_pkg.sv
// Shared memory-interface types plus TCM byte-lane helpers used by the
// TCM port controller and its alignment datapath.
package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    localparam int unsigned SCR1_TCM_LANES = 4;

    // Byte write mask for an access of the given width at byte offset off
    function automatic logic [SCR1_TCM_LANES-1:0] scr1_tcm_be(
        input type_scr1_mem_width_e width,
        input logic [1:0]           off
    );
        logic [SCR1_TCM_LANES-1:0] be;
        be = '0;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  be = 4'(4'b0001 << off);
            SCR1_MEM_WIDTH_HWORD: be = 4'(4'b0011 << off);
            SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
            default:              be = '0;
        endcase
        return be;
    endfunction

    // Unsupported width encodings are reported the same way as misalignment
    function automatic logic scr1_tcm_misaligned(
        input type_scr1_mem_width_e width,
        input logic [1:0]           off
    );
        logic mis;
        mis = 1'b0;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  mis = 1'b0;
            SCR1_MEM_WIDTH_HWORD: mis = off[0];
            SCR1_MEM_WIDTH_WORD:  mis = |off;
            default:              mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage : scr1_memif_pkg

// File: rtl/scr1_tcm_dmem_align.sv
// Combinational DMEM lane logic: store byte enables, store data replication
// and right-alignment of load data returned by the array.
module scr1_tcm_dmem_align
    import scr1_memif_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [1:0]  rd_width,
    input  logic [1:0]  rd_off,
    input  logic [31:0] qb,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c
);

    type_scr1_mem_width_e wr_w;
    type_scr1_mem_width_e rd_w;
    logic [31:0]          qb_shift;

    assign wr_w     = type_scr1_mem_width_e'(width);
    assign rd_w     = type_scr1_mem_width_e'(rd_width);
    assign be_c     = scr1_tcm_be(wr_w, off);
    assign qb_shift = qb >> {rd_off, 3'b000};

    // Replicate narrow stores across all lanes; the mask selects the live one
    always_comb begin
        wdata_c = wdata;
        case (wr_w)
            SCR1_MEM_WIDTH_BYTE:  wdata_c = {4{wdata[7:0]}};
            SCR1_MEM_WIDTH_HWORD: wdata_c = {2{wdata[15:0]}};
            default:              wdata_c = wdata;
        endcase
    end

    // Zero-extended; the core applies sign extension itself
    always_comb begin
        rdata_c = qb_shift;
        case (rd_w)
            SCR1_MEM_WIDTH_BYTE:  rdata_c = {24'h0, qb_shift[7:0]};
            SCR1_MEM_WIDTH_HWORD: rdata_c = {16'h0, qb_shift[15:0]};
            default:              rdata_c = qb_shift;
        endcase
    end

endmodule : scr1_tcm_dmem_align

// File: rtl/scr1_tcm_port_ctrl.sv
// Core-side TCM controller: IMEM fetches on array port A, DMEM loads/stores on
// port B, single-cycle response latency, no backpressure.
module scr1_tcm_port_ctrl
    import scr1_memif_pkg::*;
#(
    parameter int unsigned SCR1_SIZE  = 32'h00010000,
    parameter int unsigned SCR1_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_ack,
    input  logic                  imem_req,
    input  logic [31:0]           imem_addr,
    output logic [SCR1_WIDTH-1:0] imem_rdata,
    output logic [1:0]            imem_resp,
    output logic                  dmem_req_ack,
    input  logic                  dmem_req,
    input  logic                  dmem_cmd,
    input  logic [1:0]            dmem_width,
    input  logic [31:0]           dmem_addr,
    input  logic [SCR1_WIDTH-1:0] dmem_wdata,
    output logic [SCR1_WIDTH-1:0] dmem_rdata,
    output logic [1:0]            dmem_resp,
    output logic                  rena,
    output logic [$clog2(SCR1_SIZE)-3:0] addra,
    input  logic [SCR1_WIDTH-1:0] qa,
    output logic                  renb,
    output logic                  wenb,
    output logic [3:0]            webb,
    output logic [$clog2(SCR1_SIZE)-3:0] addrb,
    output logic [SCR1_WIDTH-1:0] datab,
    input  logic [SCR1_WIDTH-1:0] qb
);

    localparam int unsigned AW = $clog2(SCR1_SIZE);

    logic                 req_ack_q;
    type_scr1_mem_resp_e  imem_resp_q;
    logic [31:0]          imem_rdata_q;
    type_scr1_mem_resp_e  dmem_resp_q;
    logic                 dmem_rd_q;
    logic [1:0]           dmem_off_q;
    logic [1:0]           dmem_width_q;
    logic [31:0]          dmem_rdata_q;

    logic                 imem_acc;
    logic                 imem_mis;
    logic                 dmem_acc;
    logic                 dmem_mis;
    logic                 dmem_wr;
    logic [3:0]           be;
    logic [31:0]          wdata_rep;
    logic [31:0]          rdata_align;
    logic                 unused_addr;

    assign unused_addr = ^{imem_addr[31:AW], dmem_addr[31:AW]};

    assign imem_req_ack = req_ack_q;
    assign dmem_req_ack = req_ack_q;
    assign imem_resp    = imem_resp_q;
    assign dmem_resp    = dmem_resp_q;

    // Request side: array controls are driven straight from the accepted request
    assign imem_acc = imem_req & req_ack_q;
    assign imem_mis = |imem_addr[1:0];
    assign rena     = imem_acc & ~imem_mis;
    assign addra    = imem_addr[AW-1:2];

    assign dmem_acc = dmem_req & req_ack_q;
    assign dmem_mis = scr1_tcm_misaligned(type_scr1_mem_width_e'(dmem_width), dmem_addr[1:0]);
    assign dmem_wr  = (dmem_cmd == 1'(SCR1_MEM_CMD_WR));
    assign wenb     = dmem_acc & ~dmem_mis & dmem_wr;
    assign renb     = dmem_acc & ~dmem_mis & ~dmem_wr;
    assign addrb    = dmem_addr[AW-1:2];
    assign webb     = wenb ? be : 4'h0;
    assign datab    = wenb ? wdata_rep : 32'h0;

    scr1_tcm_dmem_align i_align (
        .width    (dmem_width),
        .off      (dmem_addr[1:0]),
        .wdata    (dmem_wdata),
        .rd_width (dmem_width_q),
        .rd_off   (dmem_off_q),
        .qb       (qb),
        .be_c     (be),
        .wdata_c  (wdata_rep),
        .rdata_c  (rdata_align)
    );

    // Response side: array data passes through in the response cycle, else hold
    always_comb begin
        imem_rdata = imem_rdata_q;
        if (imem_resp_q == SCR1_MEM_RESP_RDY_OK) begin
            imem_rdata = qa;
        end else if (imem_resp_q == SCR1_MEM_RESP_RDY_ER) begin
            imem_rdata = 32'h0;
        end
    end

    always_comb begin
        dmem_rdata = dmem_rdata_q;
        if (dmem_rd_q) begin
            dmem_rdata = rdata_align;
        end else if (dmem_resp_q == SCR1_MEM_RESP_RDY_ER) begin
            dmem_rdata = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ack_q    <= 1'b0;
            imem_resp_q  <= SCR1_MEM_RESP_NOTRDY;
            imem_rdata_q <= 32'h0;
            dmem_resp_q  <= SCR1_MEM_RESP_NOTRDY;
            dmem_rd_q    <= 1'b0;
            dmem_off_q   <= 2'b00;
            dmem_width_q <= 2'b00;
            dmem_rdata_q <= 32'h0;
        end else begin
            req_ack_q    <= 1'b1;
            imem_rdata_q <= imem_rdata;
            dmem_rdata_q <= dmem_rdata;
            if (!imem_acc) begin
                imem_resp_q <= SCR1_MEM_RESP_NOTRDY;
            end else if (imem_mis) begin
                imem_resp_q <= SCR1_MEM_RESP_RDY_ER;
            end else begin
                imem_resp_q <= SCR1_MEM_RESP_RDY_OK;
            end
            if (!dmem_acc) begin
                dmem_resp_q <= SCR1_MEM_RESP_NOTRDY;
            end else if (dmem_mis) begin
                dmem_resp_q <= SCR1_MEM_RESP_RDY_ER;
            end else begin
                dmem_resp_q <= SCR1_MEM_RESP_RDY_OK;
            end
            dmem_rd_q <= renb;
            if (renb) begin
                dmem_off_q   <= dmem_addr[1:0];
                dmem_width_q <= dmem_width;
            end
        end
    end

endmodule : scr1_tcm_port_ctrl

// File: tb/tb_scr1_tcm_port_ctrl.sv
// Bench for scr1_tcm_port_ctrl: directed cases from the plan, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_scr1_tcm_port_ctrl;

    localparam int AW = 16;
    localparam int R_NONE = 0;
    localparam int R_OK   = 1;
    localparam int R_ER   = 2;
    localparam int R_LOAD = 3;

    logic          clk;
    logic          rst_n;
    logic          imem_req_ack;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic [1:0]    imem_resp;
    logic          dmem_req_ack;
    logic          dmem_req;
    logic          dmem_cmd;
    logic [1:0]    dmem_width;
    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic [1:0]    dmem_resp;
    logic          rena;
    logic [AW-3:0] addra;
    logic [31:0]   qa;
    logic          renb;
    logic          wenb;
    logic [3:0]    webb;
    logic [AW-3:0] addrb;
    logic [31:0]   datab;
    logic [31:0]   qb;

    int checks;
    int errors;

    // Model state: what kind of response is owed next cycle, and held data
    int          m_ack;
    int          m_ikind;
    int          m_dkind;
    int          m_doff;
    int          m_dwid;
    logic [31:0] m_ihold;
    logic [31:0] m_dhold;

    scr1_tcm_port_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_ack (imem_req_ack),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_req_ack (dmem_req_ack),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .rena         (rena),
        .addra        (addra),
        .qa           (qa),
        .renb         (renb),
        .wenb         (wenb),
        .webb         (webb),
        .addrb        (addrb),
        .datab        (datab),
        .qb           (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] word, input int off, input int wid);
        logic [31:0] v;
        v = word >> (8 * off);
        if (wid == 0) v = v & 32'h0000_00FF;
        else if (wid == 1) v = v & 32'h0000_FFFF;
        return v;
    endfunction

    function automatic int is_misaligned(input int wid, input int off);
        if (wid == 1) return off % 2;
        if (wid == 2) return (off != 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic model_reset();
        m_ack   = 0;
        m_ikind = R_NONE;
        m_dkind = R_NONE;
        m_doff  = 0;
        m_dwid  = 0;
        m_ihold = 32'h0;
        m_dhold = 32'h0;
    endtask

    // Applied just after each rising edge, using the inputs held through it
    task automatic model_edge();
        int off;
        int wid;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_ikind = R_NONE;
        if (imem_req && m_ack == 1)
            m_ikind = (imem_addr % 4 == 0) ? R_OK : R_ER;
        m_dkind = R_NONE;
        if (dmem_req && m_ack == 1) begin
            off = int'(dmem_addr % 4);
            wid = int'(dmem_width);
            if (is_misaligned(wid, off) != 0) m_dkind = R_ER;
            else if (dmem_cmd) m_dkind = R_OK;
            else begin
                m_dkind = R_LOAD;
                m_doff  = off;
                m_dwid  = wid;
            end
        end
        m_ack = 1;
    endtask

    task automatic compare();
        logic [31:0] exp_i;
        logic [31:0] exp_d;
        int          iacc;
        int          dacc;
        int          off;
        int          wid;
        int          rs;
        chk("imem_req_ack", 32'(imem_req_ack), 32'(m_ack));
        chk("dmem_req_ack", 32'(dmem_req_ack), 32'(m_ack));

        rs = (m_ikind == R_NONE) ? 0 : m_ikind;
        chk("imem_resp", 32'(imem_resp), 32'(rs));
        exp_i = (m_ikind == R_OK) ? qa : (m_ikind == R_ER) ? 32'h0 : m_ihold;
        chk("imem_rdata", imem_rdata, exp_i);

        rs = (m_dkind == R_NONE) ? 0 : (m_dkind == R_ER) ? 2 : 1;
        chk("dmem_resp", 32'(dmem_resp), 32'(rs));
        exp_d = (m_dkind == R_LOAD) ? load_value(qb, m_doff, m_dwid) :
                (m_dkind == R_ER) ? 32'h0 : m_dhold;
        chk("dmem_rdata", dmem_rdata, exp_d);

        iacc = (imem_req && m_ack == 1) ? 1 : 0;
        if (iacc == 1 && imem_addr % 4 == 0) begin
            chk("rena", 32'(rena), 32'd1);
            chk("addra", 32'(addra), (imem_addr % 65536) / 4);
        end else begin
            chk("rena", 32'(rena), 32'd0);
        end

        dacc = (dmem_req && m_ack == 1) ? 1 : 0;
        off  = int'(dmem_addr % 4);
        wid  = int'(dmem_width);
        if (dacc == 1 && is_misaligned(wid, off) == 0) begin
            chk("addrb", 32'(addrb), (dmem_addr % 65536) / 4);
            if (dmem_cmd) begin
                chk("wenb", 32'(wenb), 32'd1);
                chk("renb", 32'(renb), 32'd0);
                if (wid == 0) begin
                    chk("webb", 32'(webb), 32'(1 << off));
                    chk("datab", datab, (dmem_wdata % 256) * 32'h0101_0101);
                end else if (wid == 1) begin
                    chk("webb", 32'(webb), 32'(3 << off));
                    chk("datab", datab, (dmem_wdata % 65536) * 32'h0001_0001);
                end else begin
                    chk("webb", 32'(webb), 32'hF);
                    chk("datab", datab, dmem_wdata);
                end
            end else begin
                chk("renb", 32'(renb), 32'd1);
                chk("wenb", 32'(wenb), 32'd0);
                chk("webb", 32'(webb), 32'd0);
            end
        end else begin
            chk("renb", 32'(renb), 32'd0);
            chk("wenb", 32'(wenb), 32'd0);
            chk("webb", 32'(webb), 32'd0);
            chk("datab", datab, 32'd0);
        end
        m_ihold = exp_i;
        m_dhold = exp_d;
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic dreq(input logic cmd, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        dmem_req   = 1'b1;
        dmem_cmd   = cmd;
        dmem_width = w;
        dmem_addr  = a;
        dmem_wdata = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        imem_req = 1'b0; imem_addr = 32'h0; qa = 32'h0;
        dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = 2'b00;
        dmem_addr = 32'h0; dmem_wdata = 32'h0; qb = 32'h0;
        model_reset();
        #1;
        chk("reset imem_resp", 32'(imem_resp), 32'd0);
        chk("reset dmem_rdata", dmem_rdata, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("ack before first edge", 32'(imem_req_ack), 32'd0);
        step();
        chk("ack after first edge", 32'(dmem_req_ack), 32'd1);
        chk("idle imem_resp", 32'(imem_resp), 32'd0);

        // IMEM directed
        imem_req = 1'b1; imem_addr = 32'h10;
        #1;
        chk("rena aligned", 32'(rena), 32'd1);
        chk("addra 0x10", 32'(addra), 32'd4);
        step();
        imem_addr = 32'h12; qa = 32'hDEAD_BEEF;
        #1;
        chk("imem ok resp", 32'(imem_resp), 32'd1);
        chk("imem ok data", imem_rdata, 32'hDEAD_BEEF);
        chk("rena misaligned", 32'(rena), 32'd0);
        step();
        imem_addr = 32'h20; qa = 32'h1111_2222;
        #1;
        chk("imem er resp", 32'(imem_resp), 32'd2);
        chk("imem er data", imem_rdata, 32'h0);
        step();
        imem_req = 1'b0; qa = 32'hCAFE_F00D;
        step();
        qa = 32'h5555_AAAA;
        #1;
        chk("imem hold resp", 32'(imem_resp), 32'd0);
        chk("imem hold data", imem_rdata, 32'hCAFE_F00D);
        step();

        // DMEM directed
        dreq(1'b1, 2'b00, 32'h103, 32'h0000_00AB);
        #1;
        chk("st byte webb", 32'(webb), 32'h8);
        chk("st byte datab", datab, 32'hABAB_ABAB);
        chk("st byte addrb", 32'(addrb), 32'h40);
        step();
        dreq(1'b0, 2'b01, 32'h102, 32'h0);
        #1;
        chk("st resp", 32'(dmem_resp), 32'd1);
        step();
        qb = 32'h1234_ABCD;
        dreq(1'b0, 2'b00, 32'h101, 32'h0);
        #1;
        chk("ld hword data", dmem_rdata, 32'h0000_1234);
        step();
        dreq(1'b1, 2'b10, 32'h102, 32'hFFFF_FFFF);
        #1;
        chk("ld byte data", dmem_rdata, 32'h0000_00AB);
        chk("misaligned wenb", 32'(wenb), 32'd0);
        step();
        dmem_req = 1'b0;
        #1;
        chk("misaligned resp", 32'(dmem_resp), 32'd2);
        chk("misaligned data", dmem_rdata, 32'h0);
        step();

        // Back-to-back RD / WR / RD
        dreq(1'b0, 2'b10, 32'h0, 32'h0);
        step();
        dreq(1'b1, 2'b10, 32'h4, 32'h0BAD_F00D);
        #1;
        chk("b2b rd1", 32'(dmem_resp), 32'd1);
        step();
        dreq(1'b0, 2'b10, 32'h8, 32'h0);
        #1;
        chk("b2b wr", 32'(dmem_resp), 32'd1);
        step();
        dmem_req = 1'b0; qb = 32'h7788_9900;
        #1;
        chk("b2b rd2", 32'(dmem_resp), 32'd1);
        chk("b2b rd2 data", dmem_rdata, 32'h7788_9900);
        step();

        // Reset while a load response is pending
        dreq(1'b0, 2'b10, 32'h20, 32'h0);
        step();
        dmem_req = 1'b0; qb = 32'h4444_4444;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst resp", 32'(dmem_resp), 32'd0);
        chk("async rst data", dmem_rdata, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("post rst resp", 32'(dmem_resp), 32'd0);
        step();
        chk("post rst edge resp", 32'(dmem_resp), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            imem_req   = 1'($urandom_range(0, 3) != 0);
            imem_addr  = $urandom;
            qa         = $urandom;
            dmem_req   = 1'($urandom_range(0, 3) != 0);
            dmem_cmd   = 1'($urandom_range(0, 1));
            dmem_width = 2'($urandom_range(0, 2));
            dmem_addr  = $urandom;
            dmem_wdata = $urandom;
            qb         = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scr1_tcm_port_ctrl
